// File: rtl/tick_gen.sv
// tick_gen: multi-channel programmable tick generator with a pixel
// clock-enable divider. Every channel counts clk50 cycles while enabled
// and emits a one-cycle tick every `per` cycles. The period of a channel
// can be written directly or shortened step by step down to a floor.
//
// Ports
//   clk50       input   1             only clock, rising edge
//   rst         input   1             synchronous active-high reset
//   pix_ce      output  1             one-cycle strobe every PIX_DIV cycles
//   ch_en       input   N_CH          per-channel count enable
//   ch_restart  input   N_CH          per-channel counter clear
//   ch_speedup  input   N_CH          per-channel period-decrement request
//   wr_en       input   1             period write strobe
//   wr_ch       input   clog2(N_CH)   channel selected for write (min 1 bit)
//   wr_period   input   CNT_W         new period value (0 is stored as 1)
//   tick        output  N_CH          registered one-cycle pulse per channel
//   period_q    output  N_CH*CNT_W    current periods, channel i at [i*CNT_W +: CNT_W]
module tick_gen #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 24,
  parameter int PIX_DIV    = 2,
  parameter int DEF_PERIOD = 10_000_000,
  parameter int STEP       = 500_000,
  parameter int MIN_PERIOD = 1_000_000
) (
  input  logic                                   clk50,
  input  logic                                   rst,
  output logic                                   pix_ce,
  input  logic [N_CH-1:0]                        ch_en,
  input  logic [N_CH-1:0]                        ch_restart,
  input  logic [N_CH-1:0]                        ch_speedup,
  input  logic                                   wr_en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
  input  logic [CNT_W-1:0]                       wr_period,
  output logic [N_CH-1:0]                        tick,
  output logic [N_CH*CNT_W-1:0]                  period_q
);

  localparam int PIX_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIX_DIV - 1);

  // The reset period is clamped after truncation to CNT_W so that a
  // default which wraps to zero still yields a usable period of 1.
  localparam logic [CNT_W-1:0] DEF_T  = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] DEF_P  = (DEF_T == '0) ? CNT_W'(1) : DEF_T;
  localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] STEP_P = CNT_W'(STEP);

  logic [PIX_W-1:0] pix_cnt;
  logic [N_CH-1:0]  wr_sel;
  logic [CNT_W-1:0] wr_value;

  // Pixel divider: pix_ce is a registered strobe, high for the single
  // cycle following the edge where the divider reaches its last value.
  always_ff @(posedge clk50) begin
    if (rst) begin
      pix_cnt <= '0;
      pix_ce  <= 1'b0;
    end else if (pix_cnt == PIX_LAST) begin
      pix_cnt <= '0;
      pix_ce  <= 1'b1;
    end else begin
      pix_cnt <= pix_cnt + PIX_W'(1);
      pix_ce  <= 1'b0;
    end
  end

  // One-hot decode of the write target; an out-of-range channel selects
  // nothing, so the write is dropped.
  always_comb begin
    wr_sel   = '0;
    wr_value = (wr_period == '0) ? CNT_W'(1) : wr_period;
    if (wr_en && (int'(wr_ch) < N_CH)) begin
      wr_sel[wr_ch] = 1'b1;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] per_dec;
    logic             tick_r;

    // Saturating speed-up: the difference to the floor is checked first,
    // so the subtraction of STEP can never underflow.
    always_comb begin
      per_dec = per;
      if (per > MIN_P) begin
        if ((per - MIN_P) <= STEP_P) begin
          per_dec = MIN_P;
        end else begin
          per_dec = per - STEP_P;
        end
      end
    end

    // Counter wraps on cnt >= per-1 rather than equality, so a period
    // shortened below the current count still produces exactly one tick
    // on the next enabled cycle. per is never 0, so per-1 cannot wrap.
    // Restart wins over the wrap; period updates are independent of it.
    always_ff @(posedge clk50) begin
      if (rst) begin
        cnt    <= '0;
        per    <= DEF_P;
        tick_r <= 1'b0;
      end else begin
        if (ch_restart[i]) begin
          cnt    <= '0;
          tick_r <= 1'b0;
        end else if (ch_en[i]) begin
          if (cnt >= (per - CNT_W'(1))) begin
            cnt    <= '0;
            tick_r <= 1'b1;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            tick_r <= 1'b0;
          end
        end else begin
          tick_r <= 1'b0;
        end

        if (wr_sel[i]) begin
          per <= wr_value;
        end else if (ch_speedup[i]) begin
          per <= per_dec;
        end
      end
    end

    assign tick[i]                     = tick_r;
    assign period_q[i*CNT_W +: CNT_W]  = per;
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb_tick_gen: self-checking bench for tick_gen with N_CH=2, CNT_W=8,
// PIX_DIV=3, DEF_PERIOD=5, STEP=2, MIN_PERIOD=2.
// A table of per-cycle vectors {inputs, expected tick/periods} is built
// first; each row is driven on the falling edge, its expectation is pushed
// to a scoreboard queue, and it is popped and compared 1 time unit after
// the following rising edge. The pix_ce expectation comes from a small
// cycle-count model kept alongside the stimulus.
module tb_tick_gen;

  logic        clk50 = 1'b0;
  logic        rst;
  logic        pix_ce;
  logic [1:0]  ch_en;
  logic [1:0]  ch_restart;
  logic [1:0]  ch_speedup;
  logic        wr_en;
  logic [0:0]  wr_ch;
  logic [7:0]  wr_period;
  logic [1:0]  tick;
  logic [15:0] period_q;

  typedef struct packed {
    logic       rst;
    logic [1:0] en;
    logic [1:0] restart;
    logic [1:0] speedup;
    logic       wr_en;
    logic       wr_ch;
    logic [7:0] wr_period;
    logic [1:0] exp_tick;
    logic [7:0] exp_per0;
    logic [7:0] exp_per1;
  } vec_t;

  typedef struct packed {
    logic [1:0] tick;
    logic       pix;
    logic [7:0] per0;
    logic [7:0] per1;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pix_age  = 0;

  tick_gen #(
    .N_CH(2), .CNT_W(8), .PIX_DIV(3), .DEF_PERIOD(5), .STEP(2), .MIN_PERIOD(2)
  ) dut (
    .clk50      (clk50),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .ch_en      (ch_en),
    .ch_restart (ch_restart),
    .ch_speedup (ch_speedup),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_period  (wr_period),
    .tick       (tick),
    .period_q   (period_q)
  );

  always #5 clk50 = ~clk50;

  function automatic void addVec(input logic r, input logic [1:0] en,
                                 input logic [1:0] rs, input logic [1:0] sp,
                                 input logic we, input logic wc,
                                 input logic [7:0] wp, input logic [1:0] tk,
                                 input logic [7:0] p0, input logic [7:0] p1);
    vec_t v;
    v.rst       = r;
    v.en        = en;
    v.restart   = rs;
    v.speedup   = sp;
    v.wr_en     = we;
    v.wr_ch     = wc;
    v.wr_period = wp;
    v.exp_tick  = tk;
    v.exp_per0  = p0;
    v.exp_per1  = p1;
    vecs.push_back(v);
  endfunction

  function automatic void check(input string name, input int idx,
                                input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s row %0d: got %0d, expected %0d", name, idx, act, req);
    end
  endfunction

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rst        = v.rst;
    ch_en      = v.en;
    ch_restart = v.restart;
    ch_speedup = v.speedup;
    wr_en      = v.wr_en;
    wr_ch      = v.wr_ch;
    wr_period  = v.wr_period;
    if (v.rst) pix_age = 0;
    else       pix_age++;
    e.tick = v.exp_tick;
    e.pix  = !v.rst && ((pix_age % 3) == 0);
    e.per0 = v.exp_per0;
    e.per1 = v.exp_per1;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL scoreboard row %0d: got empty queue, expected an entry", idx);
    end else begin
      e = sb.pop_front();
      check("tick",   idx, {6'd0, tick},   {6'd0, e.tick});
      check("pix_ce", idx, {7'd0, pix_ce}, {7'd0, e.pix});
      check("per0",   idx, period_q[7:0],  e.per0);
      check("per1",   idx, period_q[15:8], e.per1);
    end
  endtask

  initial begin
    rst        = 1'b1;
    ch_en      = 2'b00;
    ch_restart = 2'b00;
    ch_speedup = 2'b00;
    wr_en      = 1'b0;
    wr_ch      = 1'b0;
    wr_period  = 8'd0;

    // Free run: both channels tick on cycles 5,10,15 after release.
    addVec(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 15; j++)
      addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0,
             ((j % 5) == 0) ? 2'b11 : 2'b00, 8'd5, 8'd5);

    // Write period 2 to channel 0 while its count is 3; channel 1 keeps 5.
    addVec(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 3; j++)
      addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 8'd2, 2'b00, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b11, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b10, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd2, 8'd5);
    addVec(1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd2, 8'd5);

    // Speed-up saturation, write/speed-up collision, zero write, restart+write.
    addVec(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd3);
    addVec(1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd2);
    addVec(1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd2);
    addVec(1'b0, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0, 8'd9, 2'b00, 8'd9, 8'd2);
    addVec(1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 8'd0, 2'b00, 8'd7, 8'd2);
    addVec(1'b0, 2'b00, 2'b00, 2'b11, 1'b1, 1'b1, 8'd6, 2'b00, 8'd5, 8'd6);
    addVec(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b1, 8'd0, 2'b00, 8'd5, 8'd1);
    addVec(1'b0, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd1);
    addVec(1'b0, 2'b00, 2'b01, 2'b00, 1'b1, 1'b0, 8'd7, 2'b00, 8'd7, 8'd1);
    addVec(1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd1);
    addVec(1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 8'd0, 2'b00, 8'd3, 8'd1);
    addVec(1'b0, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 8'd0, 2'b00, 8'd2, 8'd1);

    // Enable hold at count 2, restart, restart over wrap, hold at wrap point.
    addVec(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 2; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 4; j++)
      addVec(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 2; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd5, 8'd5);
    for (int j = 1; j <= 2; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 4; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd5, 8'd5);
    for (int j = 1; j <= 4; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 4; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd5, 8'd5);
    for (int j = 1; j <= 4; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd5, 8'd5);

    // Reset mid-count and mid-write: period back to 5, tick 5 cycles later.
    addVec(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 8'd9, 2'b00, 8'd9, 8'd5);
    for (int j = 1; j <= 7; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd9, 8'd5);
    addVec(1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 8'd3, 2'b00, 8'd5, 8'd5);
    for (int j = 1; j <= 4; j++)
      addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b00, 8'd5, 8'd5);
    addVec(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 8'd0, 2'b01, 8'd5, 8'd5);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk50);
      applyStimulus(vecs[i]);
      @(posedge clk50);
      #1;
      checkOutput(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
